// File: rtl/prco_pipe_ctrl.sv
// prco_pipe_ctrl: multi-cycle sequencer for the PRCO core datapath.
// Steps each instruction through FETCH, DECODE, EXEC, then MEM or WB, and
// issues one-cycle stage enables. Owns the PC and halts on a decoded halt.
// Optional FETCH/MEM wait-state timeout: define PRCO_PIPE_TIMEOUT_EN.
module prco_pipe_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_run,
  input  logic        i_fetch_valid,
  input  logic        i_dec_req_ram,
  input  logic        i_dec_halt,
  input  logic        i_dec_jmp,
  input  logic [15:0] i_dec_jmp_addr,
  input  logic        i_mem_done,
  output logic        q_ce_fetch,
  output logic        q_ce_dec,
  output logic        q_ce_alu,
  output logic        q_ce_mem,
  output logic        q_ce_wb,
  output logic [15:0] q_pc,
  output logic        q_busy,
  output logic        q_halted,
  output logic        q_fault,
  output logic [2:0]  q_state
);

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                         S_EXEC = 3'd3, S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6;

  // The wait counter is 8 bits wide, so the limit must fit in 1..255.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("prco_pipe_ctrl: TIMEOUT must be in 1..255");
  end

  logic [2:0]  state, next_state;
  logic        req_ram, jmp;
  logic [15:0] jmp_addr;
  logic        retire, limit_hit, fault_set;
  logic        ce_fetch_d, ce_dec_d, ce_alu_d, ce_mem_d, ce_wb_d, busy_d, halted_d;

`ifdef PRCO_PIPE_TIMEOUT_EN
  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);
  logic [7:0] wait_cnt;
  // Limit is reached on the TIMEOUT-th cycle spent in FETCH or MEM.
  assign limit_hit = (wait_cnt == LIMIT);

  // Wait counter: restarts on every state change, saturates while parked.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n)               wait_cnt <= '0;
    else if (next_state != state) wait_cnt <= '0;
    else if (wait_cnt != 8'hFF)   wait_cnt <= wait_cnt + 8'd1;
  end
`else
  assign limit_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) state <= S_IDLE;
    else            state <= next_state;
  end

  // Next-state logic; done/valid beats the timeout in the same cycle.
  always_comb begin
    next_state = state;
    fault_set  = 1'b0;
    retire     = 1'b0;
    case (state)
      S_IDLE:   if (i_run) next_state = S_FETCH;
      S_FETCH:  begin
        if (i_fetch_valid)  next_state = S_DECODE;
        else if (limit_hit) begin next_state = S_HALT; fault_set = 1'b1; end
      end
      S_DECODE: next_state = i_dec_halt ? S_HALT : S_EXEC;
      S_EXEC:   next_state = req_ram ? S_MEM : S_WB;
      S_MEM:    begin
        if (i_mem_done) begin
          retire     = 1'b1;
          next_state = i_run ? S_FETCH : S_IDLE;
        end else if (limit_hit) begin
          next_state = S_HALT;
          fault_set  = 1'b1;
        end
      end
      S_WB:     begin
        retire     = 1'b1;
        next_state = i_run ? S_FETCH : S_IDLE;
      end
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_IDLE;
    endcase
  end

  // Output decode: strobes fire on the first cycle of their state.
  always_comb begin
    ce_fetch_d = (next_state == S_FETCH) && (state != S_FETCH);
    ce_dec_d   = (next_state == S_DECODE);
    ce_alu_d   = (next_state == S_EXEC);
    ce_mem_d   = (next_state == S_MEM) && (state != S_MEM);
    ce_wb_d    = (next_state == S_WB);
    busy_d     = (next_state != S_IDLE) && (next_state != S_HALT);
    halted_d   = (next_state == S_HALT);
  end

  // Output, PC and decode-latch registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      q_ce_fetch <= 1'b0;
      q_ce_dec   <= 1'b0;
      q_ce_alu   <= 1'b0;
      q_ce_mem   <= 1'b0;
      q_ce_wb    <= 1'b0;
      q_busy     <= 1'b0;
      q_halted   <= 1'b0;
      q_fault    <= 1'b0;
      q_pc       <= '0;
      req_ram    <= 1'b0;
      jmp        <= 1'b0;
      jmp_addr   <= '0;
    end else begin
      q_ce_fetch <= ce_fetch_d;
      q_ce_dec   <= ce_dec_d;
      q_ce_alu   <= ce_alu_d;
      q_ce_mem   <= ce_mem_d;
      q_ce_wb    <= ce_wb_d;
      q_busy     <= busy_d;
      q_halted   <= q_halted | halted_d;
      q_fault    <= q_fault | fault_set;
      if (state == S_DECODE) begin
        req_ram  <= i_dec_req_ram;
        jmp      <= i_dec_jmp;
        jmp_addr <= i_dec_jmp_addr;
      end
      if (retire) q_pc <= jmp ? jmp_addr : q_pc + 16'd1;
    end
  end

  assign q_state = state;

endmodule

// File: doc/prco_pipe_ctrl.md
# prco_pipe_ctrl

Multi-cycle sequencer for the PRCO core datapath. It steps each instruction through fetch, decode, ALU execute, then either the RAM stage or register writeback, issuing one-cycle clock-enable strobes to each stage. It owns the program counter and halts on decoder request. It sits between the instruction memory/decoder and the `prco_alu`/register file/RAM stages, and replaces free-running enables with a single controlled schedule.

## Interface
- `TIMEOUT`, 255: wait-state limit in cycles for FETCH/MEM. Used only with `PRCO_PIPE_TIMEOUT_EN`.
- `i_clk` input 1: core clock. All logic is on the rising edge.
- `i_reset_n` input 1: synchronous, active-low reset.
- `i_run` input 1: level. When 1, instructions are issued; when 0, the block idles after the current instruction retires.
- `i_fetch_valid` input 1: instruction word available, sampled in FETCH.
- `i_dec_req_ram` input 1: decoded instruction uses the RAM stage, sampled in DECODE.
- `i_dec_halt` input 1: decoded instruction is a halt, sampled in DECODE.
- `i_dec_jmp` input 1: decoded instruction redirects the PC, sampled in DECODE.
- `i_dec_jmp_addr` input 16: jump target, sampled in DECODE.
- `i_mem_done` input 1: RAM stage complete, sampled in MEM.
- `q_ce_fetch`, `q_ce_dec`, `q_ce_alu`, `q_ce_mem`, `q_ce_wb` output 1 each: stage enables. Each is a one-cycle pulse.
- `q_pc` output 16: address of the current instruction.
- `q_busy` output 1: high when the state is neither IDLE nor HALT.
- `q_halted` output 1: sticky flag, high in HALT.
- `q_fault` output 1: sticky timeout flag.
- `q_state` output 3: state encoding, for debug.

## Operation
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Encodings 7 and above are unreachable; if entered, the next state is IDLE.
- All outputs are registered.
- **Reset values:** state IDLE, `q_pc`=0, all strobes 0, `q_busy`=0, `q_halted`=0, `q_fault`=0, `q_state`=0, timeout counter 0.
- **IDLE:** go to FETCH when `i_run`=1.
- **FETCH:**
  - `q_ce_fetch`=1 only on the first cycle in the state.
  - `i_fetch_valid` is sampled every FETCH cycle, including the first. When it is 1, go to DECODE.
- **DECODE:** one cycle.
  - `q_ce_dec`=1.
  - Latch `i_dec_req_ram`, `i_dec_halt`, `i_dec_jmp` and `i_dec_jmp_addr`.
  - If halt is latched, go to HALT and skip EXEC. Otherwise go to EXEC.
- **EXEC:** one cycle.
  - `q_ce_alu`=1.
  - The ALU result is valid on the following cycle.
  - Go to MEM if `req_ram` is latched, otherwise go to WB.
- **MEM:**
  - `q_ce_mem`=1 only on the first cycle in the state.
  - Wait for `i_mem_done`=1, then retire.
- **WB:** one cycle. `q_ce_wb`=1, then retire.
- **Retire:**
  - Update `q_pc` to the latched jump address if jump is latched, otherwise to `q_pc`+1. The add is 16-bit and wraps from 0xFFFF to 0x0000.
  - Next state is FETCH if `i_run`=1, otherwise IDLE.
- **HALT:** absorbing state, exited only by reset.
  - `q_halted`=1.
  - `q_pc` stays at the address of the halt instruction.
- **`i_run` deasserted mid-instruction:** the current instruction completes and retires, then the block goes to IDLE.
- **Reset asserted in any state:** the next edge loads the reset values. An in-flight instruction is discarded and any pending strobe is cancelled.
- A done/valid input asserted outside its sampling state is ignored.

## Timing
- A non-RAM instruction with `i_fetch_valid` high on the first FETCH cycle takes 4 cycles: FETCH, DECODE, EXEC, WB.
- A RAM instruction takes 3+N cycles, where N ≥ 1 is the number of MEM cycles up to and including the cycle with `i_mem_done` high.
- Back-to-back issue: the next instruction's FETCH strobe appears in the cycle after retire. There are no bubbles beyond the states above.
- Strobes are mutually exclusive; at most one strobe is high in any cycle.
- `q_pc` changes on the edge that leaves WB or MEM. It is stable from FETCH through retire.
- From IDLE, the first `q_ce_fetch` appears one cycle after `i_run` is sampled high.

## Configuration
- Macro: `PRCO_PIPE_TIMEOUT_EN`.
- **Defined:**
  - An 8-bit wait counter clears on entry to FETCH or MEM and increments each cycle the block waits there.
  - When it reaches `TIMEOUT` without valid/done, the next state is HALT, with `q_fault`=1 and `q_halted`=1.
  - A valid/done arriving in the same cycle as the limit takes priority: the instruction proceeds normally.
- **Undefined:**
  - The block waits indefinitely in FETCH and MEM.
  - `q_fault` is tied to 0.
  - `TIMEOUT` is unused.

## Test plan
- Reset, then `i_run`=1 with `i_fetch_valid` held high and non-RAM decodes: strobes run fetch, dec, alu, wb repeating every 4 cycles, and `q_pc` goes 0, 1, 2, 3.
- RAM instruction with `i_mem_done` high on the 3rd MEM cycle: `q_ce_mem` pulses once, and retire occurs 6 cycles after FETCH entry with `q_pc`+1.
- Jump decoded with `i_dec_jmp_addr`=0x0040 at `q_pc`=0x0005: the next FETCH has `q_pc`=0x0040. From `q_pc`=0xFFFF with no jump, `q_pc` wraps to 0x0000.
- Halt decoded at `q_pc`=7: EXEC is skipped, `q_halted`=1, `q_pc` stays 7, no further strobes are issued, and `i_run` toggling is ignored until `i_reset_n`=0.
- `i_run` dropped during EXEC: the instruction retires through WB, then `q_state`=0 and `q_busy`=0. Separately, `i_reset_n`=0 during MEM returns all outputs to reset values on the next edge.
- With `PRCO_PIPE_TIMEOUT_EN` and `TIMEOUT`=4, `i_mem_done` held low: HALT is entered with `q_fault`=1 after 4 wait cycles. A rerun with `i_mem_done` high on the limit cycle completes normally with `q_fault`=0.
